cpu_trace_fifo: RTL and testbench

- Downstream observer of the single-cycle CPU; consumes the CPU's per-cycle PC, Inst and ALU result R outputs.
- Records one trace entry {PC, Inst, R} per Clk cycle into a circular buffer.
- Capture can start immediately, or on a PC-match trigger.
- Entries are drained by a debug host through a valid/ready read port, independent of capture.

---
 rtl/cpu_trace_fifo.sv | 114 +++++++++++
 tb/tb_cpu_trace_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_fifo.sv
// Trace buffer for the single-cycle CPU: records {PC, Inst, R} per cycle into a
// circular buffer, with optional PC trigger, drained through a fall-through read port.
module cpu_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [31:0]   PC,
  input  logic [31:0]   Inst,
  input  logic [31:0]   R,
  input  logic          Arm,
  input  logic          Stop,
  input  logic          TrigEn,
  input  logic [31:0]   TrigPC,
  input  logic          RdReady,
  output logic          RdValid,
  output logic [31:0]   RdPC,
  output logic [31:0]   RdInst,
  output logic [31:0]   RdR,
  output logic [AW:0]   Count,
  output logic [15:0]   Dropped,
  output logic [1:0]    State
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [95:0]   mem [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // Stop always wins over capture, including on the trigger-match cycle.
  always_comb begin
    push = 1'b0;
    if (!Stop) begin
      if (state == CAPTURE)
        push = 1'b1;
      else if (state == WAIT_TRIG && PC == TrigPC)
        push = 1'b1;
    end
  end

  assign RdValid = (Count != '0);
  assign full    = (Count == FULL_COUNT);
  assign pop     = RdValid & RdReady;
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      Count   <= '0;
      Dropped <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Arm) begin
            state   <= TrigEn ? WAIT_TRIG : CAPTURE;
            Dropped <= '0;
          end
        end
        WAIT_TRIG: begin
          if (Stop)
            state <= IDLE;
          else if (PC == TrigPC)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (Stop)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase

      if (accept)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;

      if (accept && !pop)
        Count <= Count + 1'b1;
      else if (pop && !accept)
        Count <= Count - 1'b1;

      if (drop && Dropped != 16'hFFFF)
        Dropped <= Dropped + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n && accept)
      mem[wrPtr] <= {PC, Inst, R};
  end

  assign {RdPC, RdInst, RdR} = mem[rdPtr];
  assign State = state;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Scoreboard bench for cpu_trace_fifo: a queue-based reference model predicts
// every stored entry, and a negedge monitor checks pops and status outputs.
module tb_cpu_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          Clk;
  logic          Rst_n;
  logic [31:0]   PC;
  logic [31:0]   Inst;
  logic [31:0]   R;
  logic          Arm;
  logic          Stop;
  logic          TrigEn;
  logic [31:0]   TrigPC;
  logic          RdReady;
  logic          RdValid;
  logic [31:0]   RdPC;
  logic [31:0]   RdInst;
  logic [31:0]   RdR;
  logic [AW:0]   Count;
  logic [15:0]   Dropped;
  logic [1:0]    State;

  cpu_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PC(PC), .Inst(Inst), .R(R),
    .Arm(Arm), .Stop(Stop), .TrigEn(TrigEn), .TrigPC(TrigPC),
    .RdReady(RdReady), .RdValid(RdValid), .RdPC(RdPC), .RdInst(RdInst),
    .RdR(RdR), .Count(Count), .Dropped(Dropped), .State(State)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] r;
  } entry_t;

  entry_t expectQ[$];
  int     expOcc;
  int     expState;
  int     expDropped;
  int     checks;
  int     failures;
  bit     monitorOn;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: session rules expressed over an occupancy count and a queue.
  task automatic modelStep(input bit arm, input bit stop, input bit trigEn,
                           input logic [31:0] trigPc, input entry_t e, input bit rdy);
    bit doPush;
    bit doPop;
    doPush = 1'b0;
    doPop  = (expOcc > 0) && rdy;
    if (expState == 0 || expState == 3) begin
      if (arm) begin
        expState   = trigEn ? 1 : 2;
        expDropped = 0;
      end
    end else if (expState == 1) begin
      if (stop) expState = 0;
      else if (e.pc == trigPc) begin
        expState = 2;
        doPush   = 1'b1;
      end
    end else begin
      if (stop) expState = 3;
      else doPush = 1'b1;
    end
    if (doPush) begin
      if (expOcc < DEPTH || doPop) begin
        expectQ.push_back(e);
        expOcc++;
      end else if (expDropped < 65535) begin
        expDropped++;
      end
    end
    if (doPop) expOcc--;
  endtask

  task automatic applyStimulus(input bit arm, input bit stop, input bit trigEn,
                               input logic [31:0] trigPc, input logic [31:0] pc, input bit rdy);
    entry_t e;
    e.pc   = pc;
    e.inst = $urandom;
    e.r    = $urandom;
    Arm     = arm;
    Stop    = stop;
    TrigEn  = trigEn;
    TrigPC  = trigPc;
    PC      = e.pc;
    Inst    = e.inst;
    R       = e.r;
    RdReady = rdy;
    @(posedge Clk);
    modelStep(arm, stop, trigEn, trigPc, e, rdy);
    #1;
  endtask

  task automatic applyReset();
    Rst_n = 1'b0;
    Arm = 1'b0; Stop = 1'b0; RdReady = 1'b0;
    @(posedge Clk);
    expectQ.delete();
    expOcc     = 0;
    expState   = 0;
    expDropped = 0;
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 32'hDEAD_0000 + i, rdy);
  endtask

  // Monitor: status outputs every cycle, head entry whenever a pop is presented.
  always @(negedge Clk) begin
    if (monitorOn) begin
      checkOutput("rdvalid", 32'(RdValid), 32'(expOcc != 0));
      checkOutput("count", 32'(Count), 32'(expOcc));
      checkOutput("state", 32'(State), 32'(expState));
      checkOutput("dropped", 32'(Dropped), 32'(expDropped));
      if (RdValid && RdReady) begin
        if (expectQ.size() == 0) begin
          checkOutput("pop_unexpected", 32'(RdValid), 32'd0);
        end else begin
          entry_t head;
          head = expectQ.pop_front();
          checkOutput("head_pc", RdPC, head.pc);
          checkOutput("head_inst", RdInst, head.inst);
          checkOutput("head_r", RdR, head.r);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    monitorOn = 1'b0;
    Rst_n = 1'b1; Arm = 0; Stop = 0; TrigEn = 0; TrigPC = 0;
    PC = 0; Inst = 0; R = 0; RdReady = 0;
    expectQ.delete();
    expOcc = 0; expState = 0; expDropped = 0;
    @(negedge Clk);
    applyReset();
    monitorOn = 1'b1;
    checkOutput("reset_state", 32'(State), 32'd0);
    checkOutput("reset_count", 32'(Count), 32'd0);

    $display("[TB] immediate capture of three cycles");
    applyStimulus(1, 0, 0, 32'h0, 32'h100, 0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 32'h4, 0);
    applyStimulus(0, 0, 0, 32'h0, 32'h8, 0);
    applyStimulus(0, 1, 0, 32'h0, 32'hC, 0);
    checkOutput("t1_count", 32'(Count), 32'd3);
    checkOutput("t1_state", 32'(State), 32'd3);
    checkOutput("t1_head_pc", RdPC, 32'h0);
    idleCycles(5, 1);
    checkOutput("t1_drained", 32'(RdValid), 32'd0);

    $display("[TB] PC trigger capture");
    applyStimulus(1, 0, 1, 32'h10, 32'h200, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 32'h10, 32'(i * 4), 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h18, 0);
    checkOutput("t2_count", 32'(Count), 32'd7 - 32'd5);
    checkOutput("t2_first_pc", RdPC, 32'h10);
    idleCycles(4, 1);

    $display("[TB] overflow with reads stalled");
    applyStimulus(1, 0, 0, 32'h0, 32'h300, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 32'h0, 32'h1000 + 32'(i * 4), 0);
    applyStimulus(0, 1, 0, 32'h0, 32'h2000, 0);
    checkOutput("t3_count", 32'(Count), 32'd16);
    checkOutput("t3_dropped", 32'(Dropped), 32'd4);

    $display("[TB] full buffer with concurrent drain across wrap");
    applyStimulus(1, 0, 0, 32'h0, 32'h400, 0);
    checkOutput("t4_rearm_dropped", 32'(Dropped), 32'd0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 0, 32'h0, 32'h3000 + 32'(i * 4), 1);
    checkOutput("t4_count", 32'(Count), 32'd16);
    checkOutput("t4_dropped", 32'(Dropped), 32'd0);
    applyStimulus(0, 1, 0, 32'h0, 32'h4000, 0);
    idleCycles(20, 1);
    checkOutput("t4_empty", 32'(Count), 32'd0);

    $display("[TB] arm+stop together, stop while waiting");
    applyReset();
    applyStimulus(1, 1, 0, 32'h0, 32'h500, 0);
    checkOutput("t5_armstop_state", 32'(State), 32'd2);
    applyStimulus(0, 1, 0, 32'h0, 32'h504, 0);
    applyStimulus(1, 0, 1, 32'hFFFF_0000, 32'h0, 0);
    checkOutput("t5_wait_state", 32'(State), 32'd1);
    applyStimulus(0, 1, 0, 32'hFFFF_0000, 32'h4, 0);
    checkOutput("t5_stop_wait_state", 32'(State), 32'd0);
    checkOutput("t5_stop_wait_count", 32'(Count), 32'd0);

    $display("[TB] reset mid-capture");
    applyStimulus(1, 0, 0, 32'h0, 32'h600, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 32'h0, 32'h700 + 32'(i * 4), 0);
    checkOutput("t6_count_before", 32'(Count), 32'd5);
    applyReset();
    checkOutput("t6_state", 32'(State), 32'd0);
    checkOutput("t6_count", 32'(Count), 32'd0);
    checkOutput("t6_dropped", 32'(Dropped), 32'd0);
    checkOutput("t6_rdvalid", 32'(RdValid), 32'd0);

    $display("[TB] randomized sessions");
    for (int i = 0; i < 600; i++) begin
      bit a, s, te, rdy;
      logic [31:0] tpc, pc;
      a   = ($urandom_range(0, 19) == 0);
      s   = ($urandom_range(0, 24) == 0);
      te  = $urandom_range(0, 1);
      rdy = ($urandom_range(0, 2) != 0);
      tpc = 32'($urandom_range(0, 15)) << 2;
      pc  = 32'($urandom_range(0, 15)) << 2;
      applyStimulus(a, s, te, tpc, pc, rdy);
    end
    idleCycles(20, 1);

    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
